usb_tx_encoder: RTL

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

---
 rtl/usb_tx_encoder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_encoder
// Purpose  : USB low/full-speed transmit line encoder. Loads one packet field
//            (SYNC, PID, CRC5, CRC16 or DATA) into a shift register, sends it
//            LSB first as NRZI on the D+/D- pair, inserts a stuff bit after
//            six consecutive ones, and drives SE0 for EOP or J for idle.
// Ports    : clk, n_rst (async, active-low)
//            *_load_enable     - capture the matching trans_* field this cycle
//            trans_*           - field values (SYNC 8, PID 8, CRC5 5,
//                                CRC16 16, DATA 64 bits)
//            *_transmitting    - serialize the currently loaded field
//            eop_transmitting  - drive SE0; idle_transmitting - drive J
//            dplus_out/dminus_out  - registered line outputs
//            *_bits_transmitted    - one-cycle field-complete pulses
// Params   : CLKS_PER_BIT - clock cycles per USB bit period (2..16)
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sync_load_enable,
    input  logic        pid_load_enable,
    input  logic        crc5_load_enable,
    input  logic        crc16_load_enable,
    input  logic        data_load_enable,
    input  logic [7:0]  trans_sync,
    input  logic [7:0]  trans_pid,
    input  logic [4:0]  trans_crc5,
    input  logic [15:0] trans_crc16,
    input  logic [63:0] trans_data,
    input  logic        sync_transmitting,
    input  logic        pid_transmitting,
    input  logic        crc5_transmitting,
    input  logic        crc16_transmitting,
    input  logic        data_transmitting,
    input  logic        eop_transmitting,
    input  logic        idle_transmitting,
    output logic        dplus_out,
    output logic        dminus_out,
    output logic        sync_bits_transmitted,
    output logic        pid_bits_transmitted,
    output logic        crc5_bits_transmitted,
    output logic        crc16_bits_transmitted,
    output logic        data_bits_transmitted
);

    localparam logic [3:0] c_TIMER_MAX = 4'(CLKS_PER_BIT - 1);
    localparam logic [2:0] c_STUFF_RUN = 3'd6;

    typedef enum logic [2:0] {
        FIELD_NONE  = 3'd0,
        FIELD_SYNC  = 3'd1,
        FIELD_PID   = 3'd2,
        FIELD_CRC5  = 3'd3,
        FIELD_CRC16 = 3'd4,
        FIELD_DATA  = 3'd5
    } field_t;

    // Registered state
    logic [63:0] r_shift;
    field_t      r_field;
    logic [6:0]  r_len;
    logic [6:0]  r_index;
    logic [3:0]  r_timer;
    logic [2:0]  r_ones;
    logic        r_dplus;
    logic        r_dminus;

    // Combinational decode
    logic        w_load;
    field_t      w_load_field;
    logic [6:0]  w_load_len;
    logic [63:0] w_load_value;
    logic        w_shifting;
    logic        w_stuff;
    logic        w_bits_left;
    logic        w_last_bit;
    logic        w_bit_start;
    logic        w_bit_end;
    logic        w_toggle;
    logic        w_consume_stuff;
    logic        w_consume_bit;
    logic        w_field_done;

    // Load selection: first enable in sync > pid > crc5 > crc16 > data wins.
    always_comb begin
        w_load       = 1'b0;
        w_load_field = FIELD_NONE;
        w_load_len   = 7'd0;
        w_load_value = 64'd0;
        if (sync_load_enable) begin
            w_load       = 1'b1;
            w_load_field = FIELD_SYNC;
            w_load_len   = 7'd8;
            w_load_value = {56'd0, trans_sync};
        end else if (pid_load_enable) begin
            w_load       = 1'b1;
            w_load_field = FIELD_PID;
            w_load_len   = 7'd8;
            w_load_value = {56'd0, trans_pid};
        end else if (crc5_load_enable) begin
            w_load       = 1'b1;
            w_load_field = FIELD_CRC5;
            w_load_len   = 7'd5;
            w_load_value = {59'd0, trans_crc5};
        end else if (crc16_load_enable) begin
            w_load       = 1'b1;
            w_load_field = FIELD_CRC16;
            w_load_len   = 7'd16;
            w_load_value = {48'd0, trans_crc16};
        end else if (data_load_enable) begin
            w_load       = 1'b1;
            w_load_field = FIELD_DATA;
            w_load_len   = 7'd64;
            w_load_value = trans_data;
        end
    end

    // A load always wins over the transmitting flags in the same cycle.
    assign w_shifting = (sync_transmitting | pid_transmitting | crc5_transmitting |
                         crc16_transmitting | data_transmitting) & ~w_load;

    // Six ones in a row means the next bit period is a stuff bit. The run
    // length is carried across field boundaries, so a stuff bit may be owed
    // after a field's last bit or before the next field's first bit.
    assign w_stuff     = (r_ones == c_STUFF_RUN);
    assign w_bits_left = (r_index < r_len);
    assign w_last_bit  = (r_index == (r_len - 7'd1));
    assign w_bit_start = w_shifting & (r_timer == 4'd0);
    assign w_bit_end   = w_shifting & (r_timer == c_TIMER_MAX);

    // NRZI: a 0 or a stuff bit toggles the line at the start of its period.
    assign w_toggle        = w_bit_start & (w_stuff | (w_bits_left & ~r_shift[0]));
    assign w_consume_stuff = w_bit_end & w_stuff;
    assign w_consume_bit   = w_bit_end & ~w_stuff & w_bits_left;

    // Field completes either on its last bit (when that bit does not push the
    // run to six) or on the stuff bit owed by its last bit. Once index reaches
    // len with no stuff pending nothing is consumed, so no second pulse.
    assign w_field_done =
        (w_consume_bit & w_last_bit & ~(r_shift[0] & (r_ones == (c_STUFF_RUN - 3'd1)))) |
        (w_consume_stuff & (r_len != 7'd0) & (r_index == r_len));

    assign sync_bits_transmitted  = w_field_done & (r_field == FIELD_SYNC);
    assign pid_bits_transmitted   = w_field_done & (r_field == FIELD_PID);
    assign crc5_bits_transmitted  = w_field_done & (r_field == FIELD_CRC5);
    assign crc16_bits_transmitted = w_field_done & (r_field == FIELD_CRC16);
    assign data_bits_transmitted  = w_field_done & (r_field == FIELD_DATA);

    assign dplus_out  = r_dplus;
    assign dminus_out = r_dminus;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift  <= 64'd0;
            r_field  <= FIELD_NONE;
            r_len    <= 7'd0;
            r_index  <= 7'd0;
            r_timer  <= 4'd0;
            r_ones   <= 3'd0;
            r_dplus  <= 1'b1;
            r_dminus <= 1'b0;
        end else begin
            // Field shift register and bit index
            if (w_load) begin
                r_shift <= w_load_value;
                r_field <= w_load_field;
                r_len   <= w_load_len;
                r_index <= 7'd0;
            end else if (w_consume_bit) begin
                r_shift <= {1'b0, r_shift[63:1]};
                r_index <= r_index + 7'd1;
            end

            // Bit timer: wraps only while shifting, otherwise holds
            if (w_load || (idle_transmitting && !eop_transmitting)) begin
                r_timer <= 4'd0;
            end else if (w_shifting) begin
                r_timer <= (r_timer == c_TIMER_MAX) ? 4'd0 : r_timer + 4'd1;
            end

            // Consecutive-ones run length for bit stuffing
            if (sync_load_enable || eop_transmitting || idle_transmitting) begin
                r_ones <= 3'd0;
            end else if (w_consume_stuff) begin
                r_ones <= 3'd0;
            end else if (w_consume_bit) begin
                r_ones <= r_shift[0] ? r_ones + 3'd1 : 3'd0;
            end

            // Line register. Toggle goes to J from anything that is not J,
            // so leaving SE0 never produces the illegal (1,1) state.
            if (eop_transmitting) begin
                r_dplus  <= 1'b0;
                r_dminus <= 1'b0;
            end else if (idle_transmitting) begin
                r_dplus  <= 1'b1;
                r_dminus <= 1'b0;
            end else if (w_toggle) begin
                r_dplus  <= ~r_dplus;
                r_dminus <= r_dplus;
            end
        end
    end

endmodule
`default_nettype wire
